vx_commit_wb_arb: RTL and testbench
===================================

# VX_commit_wb_arb

Receiving end of the per-unit commit interface. Collects commit responses from `NUM_SRCS` execute units (ALU, LSU, CSR, MUL/DIV, FPU, ...), arbitrates them round-robin into a single registered register-file writeback port, and counts retired instructions. Sits between the execute units' commit outputs and the register file's write port inside each core.

## Interface
Parameters:
- `NUM_SRCS`, 4: number of commit sources; index 0 is the lowest index.
- `NUM_THREADS`, `NUM_THREADS`: lanes per commit beat.
- `NW_BITS`, `NW_BITS`: warp id width.
- `NR_BITS`, `NR_BITS`: register id width.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `in_valid`  in  NUM_SRCS  per-source commit valid
- `in_ready`  out  NUM_SRCS  per-source accept
- `in_wid`  in  NUM_SRCS*NW_BITS  warp id
- `in_tmask`  in  NUM_SRCS*NUM_THREADS  thread mask
- `in_PC`  in  NUM_SRCS*32  instruction PC
- `in_rd`  in  NUM_SRCS*NR_BITS  destination register
- `in_wb`  in  NUM_SRCS  1 = write rd
- `in_eop`  in  NUM_SRCS  last beat of the instruction
- `in_data`  in  NUM_SRCS*NUM_THREADS*32  per-lane result
- `wb_valid`  out  1  register-file write valid
- `wb_ready`  in  1  register file accepts the write
- `wb_wid`, `wb_tmask`, `wb_PC`, `wb_rd`, `wb_data`  out  matching widths  write payload
- `commit_fire`  out  NUM_SRCS  one-hot: source accepted this cycle
- `instret`  out  64  retired-instruction counter

## Operation
- Stall: `stall = wb_valid && !wb_ready`. The output register loads only when `!stall`.
- Grant, combinational, when not locked:
  - Choose the first valid source at or after `rr_ptr`, wrapping modulo NUM_SRCS.
  - When no source is valid, there is no grant.
- Lock:
  - A fired beat with `eop=0` sets `lock=1` and `lock_idx=granted`.
  - While locked, only `lock_idx` can be granted. Other sources wait even if valid.
  - A fired beat from `lock_idx` with `eop=1` clears `lock`.
- `in_ready[i] = grant[i] && !stall`. A fire is `in_valid[i] && in_ready[i]`. At most one fire per cycle.
- `rr_ptr` update:
  - On a fire with `eop=1`, `rr_ptr` becomes `(granted+1) mod NUM_SRCS`.
  - Otherwise `rr_ptr` is unchanged.
- Output register, loaded when `!stall`:
  - `wb_valid` is set to `fire && in_wb[granted]`.
  - The payload copies the granted source's fields.
  - Beats with `wb=0` are consumed and counted but produce no write.
  - When there is no fire, `wb_valid` is set to 0 and the payload holds its previous value.
- `instret` increments by 1 for each fired beat with `eop=1`. It wraps modulo 2^64.
- `commit_fire` is the combinational fire vector.

## Timing
- Latency: a beat accepted in cycle N appears on `wb_*` in cycle N+1.
- Throughput: one beat per cycle with no bubbles across sources.
- Backpressure:
  - While `stall` is high, all `in_ready` are 0 and the `wb_*` outputs hold stable.
  - Grant, `rr_ptr` and lock do not change while stalled.
- Sources must hold `valid` and the payload stable until they fire. The arbiter may change grant between cycles only when no fire occurs, for example when a newly valid higher-priority source appears.
- Reset values:
  - `wb_valid=0`, `wb_wid=0`, `wb_tmask=0`, `wb_PC=0`, `wb_rd=0`, `wb_data=0`.
  - `rr_ptr=0`, `lock=0`, `lock_idx=0`, `instret=0`.
  - `in_ready=0` and `commit_fire=0`, because `wb_valid=0` and there is no valid input.
- Reset mid-lock: clears the lock. In-flight multi-beat state is discarded and the next beat starts arbitration fresh from source 0.
- Simultaneous fire and `wb_ready` drop: the fire happened under `!stall` of the current cycle. The new beat is registered and then held.

## Test plan
- Single source 2 issues one beat (`wb=1`, `rd=5`, `data=0xDEADBEEF` on all lanes, `tmask=0xF`) -> next cycle `wb_valid=1`, `wb_rd=5`, `wb_data=0xDEADBEEF`; `instret=1`; `rr_ptr=3`.
- All 4 sources continuously valid with single-beat commits -> grant order 0,1,2,3,0,1,...; one `wb_valid` per cycle; after 8 cycles `instret=8`.
- Source 1 sends 3 beats (`eop=0,0,1`) while source 0 is valid -> source 1 beats are granted back-to-back, then source 2 if valid, else source 0.
- Hold `wb_ready=0` for 3 cycles while `wb_valid=1` -> `in_ready` is all 0; `wb_*` stays unchanged; after release, one beat per cycle resumes with no loss or duplication.
- Source 3 commit with `wb=0`, `eop=1` -> `wb_valid` is 0 the next cycle; `instret` increments; `commit_fire=4'b1000` in the accept cycle.
- Assert `reset` while a source-1 lock is active -> all outputs and state return to reset values; a fresh source-2 beat is then granted normally.

Source files
------------

// File: rtl/vx_commit_wb_arb_if.sv
// Commit-side bundle: per-source commit beats in, single register-file write out.
interface vx_commit_wb_arb_if #(
    parameter int unsigned NUM_SRCS    = 4,
    parameter int unsigned NUM_THREADS = 4,
    parameter int unsigned NW_BITS     = 2,
    parameter int unsigned NR_BITS     = 5
);
    logic [NUM_SRCS-1:0]                in_valid;
    logic [NUM_SRCS-1:0]                in_ready;
    logic [NUM_SRCS*NW_BITS-1:0]        in_wid;
    logic [NUM_SRCS*NUM_THREADS-1:0]    in_tmask;
    logic [NUM_SRCS*32-1:0]             in_PC;
    logic [NUM_SRCS*NR_BITS-1:0]        in_rd;
    logic [NUM_SRCS-1:0]                in_wb;
    logic [NUM_SRCS-1:0]                in_eop;
    logic [NUM_SRCS*NUM_THREADS*32-1:0] in_data;

    logic                               wb_valid;
    logic                               wb_ready;
    logic [NW_BITS-1:0]                 wb_wid;
    logic [NUM_THREADS-1:0]             wb_tmask;
    logic [31:0]                        wb_PC;
    logic [NR_BITS-1:0]                 wb_rd;
    logic [NUM_THREADS*32-1:0]          wb_data;

    logic [NUM_SRCS-1:0]                commit_fire;
    logic [63:0]                        instret;

    // Arbiter side
    modport slave (
        input  in_valid, in_wid, in_tmask, in_PC, in_rd, in_wb, in_eop, in_data, wb_ready,
        output in_ready, wb_valid, wb_wid, wb_tmask, wb_PC, wb_rd, wb_data, commit_fire, instret
    );

    // Execute units / register file side
    modport master (
        output in_valid, in_wid, in_tmask, in_PC, in_rd, in_wb, in_eop, in_data, wb_ready,
        input  in_ready, wb_valid, wb_wid, wb_tmask, wb_PC, wb_rd, wb_data, commit_fire, instret
    );
endinterface

// File: rtl/vx_commit_wb_arb.sv
// Round-robin commit arbiter with multi-beat lock, registered writeback and retire counter.
module vx_commit_wb_arb #(
    parameter int unsigned NUM_SRCS    = 4,
    parameter int unsigned NUM_THREADS = 4,
    parameter int unsigned NW_BITS     = 2,
    parameter int unsigned NR_BITS     = 5
) (
    input  logic              clk,
    input  logic              reset,
    vx_commit_wb_arb_if.slave bus
);
    localparam int unsigned IDX_W  = (NUM_SRCS > 1) ? $clog2(NUM_SRCS) : 1;
    localparam int unsigned LANE_W = NUM_THREADS * 32;

    typedef enum logic {ST_FREE, ST_LOCKED} state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    rr_ptr, rr_ptr_d;
    logic [IDX_W-1:0]    lock_idx, lock_idx_d;
    logic [IDX_W-1:0]    grant_idx;
    logic [IDX_W-1:0]    cand;
    logic [NUM_SRCS-1:0] grant;
    logic                grant_any;
    logic                stall;
    logic                fire;
    logic                fire_eop;

    // Grant selection: locked source only, else first valid at/after rr_ptr
    always_comb begin
        stall     = bus.wb_valid && !bus.wb_ready;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = '0;
        if (state_q == ST_LOCKED) begin
            grant_idx = lock_idx;
            grant_any = bus.in_valid[lock_idx];
        end else begin
            for (int unsigned k = 0; k < NUM_SRCS; k++) begin
                cand = IDX_W'((32'(rr_ptr) + k) % NUM_SRCS);
                if (!grant_any && bus.in_valid[cand]) begin
                    grant_any = 1'b1;
                    grant_idx = cand;
                end
            end
        end
        grant    = grant_any ? (NUM_SRCS'(1) << grant_idx) : '0;
        fire     = grant_any && !stall;
        fire_eop = fire && bus.in_eop[grant_idx];
    end

    assign bus.in_ready    = stall ? '0 : grant;
    assign bus.commit_fire = bus.in_valid & bus.in_ready;

    // Next lock state and round-robin pointer
    always_comb begin
        state_d    = state_q;
        lock_idx_d = lock_idx;
        rr_ptr_d   = rr_ptr;
        if (fire) begin
            if (!bus.in_eop[grant_idx]) begin
                state_d    = ST_LOCKED;
                lock_idx_d = grant_idx;
            end else begin
                state_d  = ST_FREE;
                rr_ptr_d = (grant_idx == IDX_W'(NUM_SRCS - 1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    // Arbitration state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_FREE;
            lock_idx <= '0;
            rr_ptr   <= '0;
        end else begin
            state_q  <= state_d;
            lock_idx <= lock_idx_d;
            rr_ptr   <= rr_ptr_d;
        end
    end

    // Writeback register: loads when not stalled, payload only moves on a fire
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.wb_valid <= 1'b0;
            bus.wb_wid   <= '0;
            bus.wb_tmask <= '0;
            bus.wb_PC    <= '0;
            bus.wb_rd    <= '0;
            bus.wb_data  <= '0;
        end else if (!stall) begin
            bus.wb_valid <= fire && bus.in_wb[grant_idx];
            if (fire) begin
                bus.wb_wid   <= bus.in_wid[grant_idx*NW_BITS +: NW_BITS];
                bus.wb_tmask <= bus.in_tmask[grant_idx*NUM_THREADS +: NUM_THREADS];
                bus.wb_PC    <= bus.in_PC[grant_idx*32 +: 32];
                bus.wb_rd    <= bus.in_rd[grant_idx*NR_BITS +: NR_BITS];
                bus.wb_data  <= bus.in_data[grant_idx*LANE_W +: LANE_W];
            end
        end
    end

    // Retired-instruction counter: one per final beat
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.instret <= '0;
        end else if (fire_eop) begin
            bus.instret <= bus.instret + 64'd1;
        end
    end
endmodule

// File: tb/tb_vx_commit_wb_arb.sv
// Randomized scoreboard bench for vx_commit_wb_arb.
module tb_vx_commit_wb_arb;
    localparam int unsigned NS = 4;
    localparam int unsigned NT = 4;
    localparam int unsigned NW = 2;
    localparam int unsigned NR = 5;

    typedef struct packed {
        logic [NW-1:0]    wid;
        logic [NT-1:0]    tmask;
        logic [31:0]      pc;
        logic [NR-1:0]    rd;
        logic             wb;
        logic             eop;
        logic [NT*32-1:0] data;
    } beat_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vx_commit_wb_arb_if #(.NUM_SRCS(NS), .NUM_THREADS(NT), .NW_BITS(NW), .NR_BITS(NR)) bus ();

    vx_commit_wb_arb #(.NUM_SRCS(NS), .NUM_THREADS(NT), .NW_BITS(NW), .NR_BITS(NR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Source-side stimulus state
    beat_t cur [NS];
    bit    has [NS];
    bit    act [NS];
    int    left[NS];
    int    gen_pct, act_pct, rdy_pct, max_len;

    // Reference model state
    beat_t           exp_q[$];
    int              rr_m;
    int              lock_m;
    bit              wbv_m;
    longint unsigned instret_m;

    int checks = 0;
    int passes = 0;

    function automatic void chk(string nm, logic [127:0] actual, logic [127:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, actual, expected, $time);
    endfunction

    function automatic bit pct(int p);
        return $urandom_range(99, 0) < p;
    endfunction

    function automatic beat_t rand_beat(bit eop);
        beat_t b;
        b.wid   = NW'($urandom);
        b.tmask = NT'($urandom);
        b.pc    = $urandom & 32'hFFFF_FFFC;
        b.rd    = NR'($urandom);
        b.wb    = pct(75);
        b.eop   = eop;
        for (int l = 0; l < NT; l++) b.data[l*32 +: 32] = $urandom;
        return b;
    endfunction

    task automatic drive();
        for (int s = 0; s < NS; s++) begin
            bus.in_valid[s]             = act[s];
            bus.in_wid[s*NW +: NW]      = cur[s].wid;
            bus.in_tmask[s*NT +: NT]    = cur[s].tmask;
            bus.in_PC[s*32 +: 32]       = cur[s].pc;
            bus.in_rd[s*NR +: NR]       = cur[s].rd;
            bus.in_wb[s]                = cur[s].wb;
            bus.in_eop[s]               = cur[s].eop;
            bus.in_data[s*NT*32 +: NT*32] = cur[s].data;
        end
    endtask

    task automatic clear_sources();
        for (int s = 0; s < NS; s++) begin
            has[s] = 0; act[s] = 0; left[s] = 0; cur[s] = '0;
        end
    endtask

    task automatic model_reset();
        rr_m = 0; lock_m = -1; wbv_m = 0; instret_m = 0;
        exp_q.delete();
    endtask

    task automatic check_reset_state();
        chk("rst_wb_valid", 128'(bus.wb_valid), 128'(0));
        chk("rst_wb_wid", 128'(bus.wb_wid), 128'(0));
        chk("rst_wb_tmask", 128'(bus.wb_tmask), 128'(0));
        chk("rst_wb_pc", 128'(bus.wb_PC), 128'(0));
        chk("rst_wb_rd", 128'(bus.wb_rd), 128'(0));
        chk("rst_wb_data", 128'(bus.wb_data), 128'(0));
        chk("rst_instret", 128'(bus.instret), 128'(0));
        chk("rst_in_ready", 128'(bus.in_ready), 128'(0));
        chk("rst_commit_fire", 128'(bus.commit_fire), 128'(0));
    endtask

    // One clock: predict the fire from the arbitration rules, then advance sources
    task automatic cycle();
        int          exp_src;
        bit          stall_m;
        beat_t       b;
        logic [NS-1:0] oh;
        @(negedge clk);
        #1;
        stall_m = wbv_m && !bus.wb_ready;
        exp_src = -1;
        b       = '0;
        if (!stall_m) begin
            if (lock_m >= 0) begin
                if (act[lock_m]) exp_src = lock_m;
            end else begin
                for (int k = 0; k < NS; k++) begin
                    if (exp_src < 0 && act[(rr_m + k) % NS]) exp_src = (rr_m + k) % NS;
                end
            end
        end
        oh = (exp_src >= 0) ? (NS'(1) << exp_src) : '0;
        chk("commit_fire", 128'(bus.commit_fire), 128'(oh));
        chk("in_ready", 128'(bus.in_ready), 128'(oh));
        chk("wb_valid", 128'(bus.wb_valid), 128'(wbv_m));
        chk("instret", 128'(bus.instret), 128'(instret_m));
        if (exp_src >= 0) begin
            b = cur[exp_src];
            if (b.wb) exp_q.push_back(b);
            if (b.eop) begin
                instret_m++;
                rr_m   = (exp_src + 1) % NS;
                lock_m = -1;
            end else begin
                lock_m = exp_src;
            end
        end
        if (!stall_m) wbv_m = (exp_src >= 0) && b.wb;

        @(posedge clk);
        #1;
        if (exp_src >= 0) begin
            if (left[exp_src] > 0) begin
                cur[exp_src] = rand_beat(left[exp_src] == 1);
                left[exp_src]--;
                act[exp_src] = pct(act_pct);
            end else begin
                has[exp_src] = 0;
                act[exp_src] = 0;
            end
        end
        for (int s = 0; s < NS; s++) begin
            if (!has[s]) begin
                if (pct(gen_pct)) begin
                    int len;
                    len     = $urandom_range(max_len, 1);
                    cur[s]  = rand_beat(len == 1);
                    left[s] = len - 1;
                    has[s]  = 1;
                    act[s]  = pct(act_pct);
                end
            end else if (!act[s]) begin
                act[s] = pct(act_pct);
            end
        end
        bus.wb_ready = pct(rdy_pct);
        drive();
    endtask

    task automatic load_src2_beat();
        cur[2].wid   = NW'(1);
        cur[2].tmask = NT'(4'hF);
        cur[2].pc    = 32'h0000_1000;
        cur[2].rd    = NR'(5);
        cur[2].wb    = 1'b1;
        cur[2].eop   = 1'b1;
        for (int l = 0; l < NT; l++) cur[2].data[l*32 +: 32] = 32'hDEAD_BEEF;
        has[2] = 1; act[2] = 1; left[2] = 0;
        drive();
    endtask

    // Monitor: every presented write must match the oldest expected one; pop on handshake
    always @(negedge clk) begin
        if (!reset && bus.wb_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL wb_unexpected: got write rd=%0h expected none at %0t", bus.wb_rd, $time);
            end else begin
                chk("wb_wid", 128'(bus.wb_wid), 128'(exp_q[0].wid));
                chk("wb_tmask", 128'(bus.wb_tmask), 128'(exp_q[0].tmask));
                chk("wb_pc", 128'(bus.wb_PC), 128'(exp_q[0].pc));
                chk("wb_rd", 128'(bus.wb_rd), 128'(exp_q[0].rd));
                chk("wb_data", 128'(bus.wb_data), 128'(exp_q[0].data));
                if (bus.wb_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        reset = 1'b1;
        bus.wb_ready = 1'b1;
        clear_sources();
        model_reset();
        drive();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_reset_state();
        @(posedge clk);
        #1;

        // Single source-2 beat
        gen_pct = 0; act_pct = 100; rdy_pct = 100; max_len = 1;
        load_src2_beat();
        repeat (3) cycle();

        // All sources continuously valid, single-beat commits
        gen_pct = 100;
        repeat (10) cycle();

        // Mixed multi-beat traffic with backpressure
        gen_pct = 40; act_pct = 70; rdy_pct = 70; max_len = 3;
        repeat (600) cycle();

        // Long stall windows
        rdy_pct = 20;
        repeat (100) cycle();

        // Run until a lock is active, then reset in the middle of it
        rdy_pct = 80;
        for (int i = 0; i < 2000 && lock_m < 0; i++) cycle();
        if (lock_m < 0) begin
            checks++;
            $display("FAIL lock_reached: got no lock expected lock within bound at %0t", $time);
        end
        reset = 1'b1;
        bus.wb_ready = 1'b1;
        clear_sources();
        drive();
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        @(negedge clk);
        check_reset_state();
        @(posedge clk);
        #1;

        // Fresh beat after reset
        gen_pct = 0; act_pct = 100; rdy_pct = 100; max_len = 1;
        load_src2_beat();
        repeat (3) cycle();

        // Random tail, then drain everything
        gen_pct = 50; act_pct = 60; rdy_pct = 60; max_len = 3;
        repeat (300) cycle();
        gen_pct = 0; act_pct = 100; rdy_pct = 100;
        repeat (30) cycle();
        chk("drain_empty", 128'(exp_q.size()), 128'(0));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
